mac_stream_engine: RTL and testbench

// Parametrised output-stationary MAC engine, successor to the fixed 4-lane systolic top. Streams one

---
 rtl/mac_stream_engine.sv | 180 ++++++++++++++++++
 tb/tb_mac_stream_engine.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_stream_engine.sv
// -----------------------------------------------------------------------------
// mac_stream_engine
// Output-stationary multiply-accumulate engine with N_MACS lanes.
// Each accepted input beat carries one activation and one weight per lane.
// Every lane accumulates K beats, where K is latched at start. Results then
// drain one lane per output handshake.
//
// Ports
//   clk, rst               clock (rising edge); asynchronous active-low reset
//   start, abort           job request (IDLE only); synchronous cancel
//   len, sat_en            beat count K and saturate/wrap mode, both latched at start
//   in_valid/in_ready      input beat handshake
//   in_a, in_w             signed activation; lane i weight = in_w[i*W +: W]
//   out_valid/out_ready    result handshake
//   out_data, out_lane     lane accumulator and its index
//   out_last               high with the final lane's result
//   ovf                    per-lane sticky overflow for the current or last job
//   busy, done             engine not idle; one-cycle pulse after the last result
// -----------------------------------------------------------------------------
module mac_stream_engine #(
  parameter int W      = 8,
  parameter int ACC_W  = 16,
  parameter int N_MACS = 4,
  parameter int LEN_W  = 8,
  localparam int LANE_W = (N_MACS > 1) ? $clog2(N_MACS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [LEN_W-1:0]         len,
  input  logic                     sat_en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [W-1:0]      in_a,
  input  logic [N_MACS*W-1:0]      in_w,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic [LANE_W-1:0]        out_lane,
  output logic                     out_last,
  output logic [N_MACS-1:0]        ovf,
  output logic                     busy,
  output logic                     done
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_MACS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DRAIN} state_t;

  state_t                  state;
  logic [LEN_W-1:0]        cnt;
  logic [LEN_W-1:0]        len_q;
  logic                    sat_q;

  logic signed [2*W-1:0]   prod_p0 [N_MACS];
  logic signed [2*W-1:0]   prod_p1 [N_MACS];
  logic                    vld_p1;
  logic signed [ACC_W-1:0] acc_nxt_p1 [N_MACS];
  logic [N_MACS-1:0]       ovf_hit_p1;
  logic signed [ACC_W-1:0] acc_p2 [N_MACS];

  // Adds a sign-extended product to an accumulator in ACC_W+1 bits.
  // Returns {overflow, result}. On overflow, sat clamps toward the sign of
  // the true sum; otherwise the low ACC_W bits are kept (wrap).
  function automatic logic [ACC_W:0] acc_add(input logic signed [ACC_W-1:0] a,
                                             input logic signed [2*W-1:0]   p,
                                             input logic                    sat);
    logic signed [ACC_W:0] sum;
    logic                  ovfl;
    logic [ACC_W-1:0]      res;
    sum  = $signed({a[ACC_W-1], a}) + $signed({{(ACC_W+1-2*W){p[2*W-1]}}, p});
    ovfl = sum[ACC_W] ^ sum[ACC_W-1];
    if (ovfl && sat)
      res = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      res = sum[ACC_W-1:0];
    return {ovfl, res};
  endfunction

  // ---- stage 0: lane products from the live input beat ----
  always_comb begin
    for (int i = 0; i < N_MACS; i++)
      prod_p0[i] = in_a * $signed(in_w[i*W +: W]);
  end

  // ---- stage 1 -> 2: accumulate the registered products ----
  always_comb begin
    ovf_hit_p1 = '0;
    for (int i = 0; i < N_MACS; i++)
      {ovf_hit_p1[i], acc_nxt_p1[i]} = acc_add(acc_p2[i], prod_p1[i], sat_q);
  end

  assign in_ready = (state == ACCUM);
  assign busy     = (state != IDLE);
  assign out_data = out_valid ? acc_p2[out_lane] : '0;
  assign out_last = out_valid && (out_lane == LAST_LANE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      len_q     <= '0;
      sat_q     <= 1'b0;
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
      out_lane  <= '0;
      done      <= 1'b0;
      ovf       <= '0;
      for (int i = 0; i < N_MACS; i++) begin
        prod_p1[i] <= '0;
        acc_p2[i]  <= '0;
      end
    end else begin
      done   <= 1'b0;
      vld_p1 <= 1'b0;
      // Abort wins over everything. The in-flight product is dropped by
      // vld_p1 clearing. The accumulators and ovf keep their values.
      if (abort && state != IDLE) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_lane  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              len_q    <= len;
              sat_q    <= sat_en;
              cnt      <= '0;
              ovf      <= '0;
              out_lane <= '0;
              for (int i = 0; i < N_MACS; i++) acc_p2[i] <= '0;
              if (len == '0) begin
                state     <= DRAIN;
                out_valid <= 1'b1;
              end else begin
                state <= ACCUM;
              end
            end
          end
          ACCUM: begin
            if (in_valid) begin
              prod_p1 <= prod_p0;
              vld_p1  <= 1'b1;
              cnt     <= cnt + 1'b1;
              if (cnt == len_q - 1'b1) state <= FLUSH;
            end
            if (vld_p1) begin
              acc_p2 <= acc_nxt_p1;
              ovf    <= ovf | ovf_hit_p1;
            end
          end
          FLUSH: begin
            if (vld_p1) begin
              acc_p2 <= acc_nxt_p1;
              ovf    <= ovf | ovf_hit_p1;
            end
            state     <= DRAIN;
            out_valid <= 1'b1;
            out_lane  <= '0;
          end
          DRAIN: begin
            if (out_ready) begin
              if (out_lane == LAST_LANE) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_lane  <= '0;
                done      <= 1'b1;
              end else begin
                out_lane <= out_lane + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_stream_engine.sv
// -----------------------------------------------------------------------------
// tb_mac_stream_engine
// Directed bench for mac_stream_engine (W=8, ACC_W=16, N_MACS=4, LEN_W=8).
// Inputs change on the falling edge. Outputs are sampled on the falling edge,
// before new inputs are driven.
// -----------------------------------------------------------------------------
module tb_mac_stream_engine;
  logic               clk = 1'b0;
  logic               rst;
  logic               start, abort, sat_en, in_valid, in_ready, out_valid, out_ready;
  logic               out_last, busy, done;
  logic [7:0]         len;
  logic signed [7:0]  in_a;
  logic [31:0]        in_w;
  logic signed [15:0] out_data;
  logic [1:0]         out_lane;
  logic [3:0]         ovf;

  int n_cmp = 0;
  int n_err = 0;
  logic signed [7:0]  a_vec [8];
  logic signed [31:0] exp_v [4];

  mac_stream_engine #(.W(8), .ACC_W(16), .N_MACS(4), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .len(len), .sat_en(sat_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_w(in_w),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lane(out_lane), .out_last(out_last), .ovf(ovf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic start_job(input logic [7:0] l, input logic s);
    @(negedge clk);
    start = 1'b1; len = l; sat_en = s;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Feeds n beats from a_vec with a fixed weight word. Returns on the
  // falling edge that follows the edge accepting the final beat.
  task automatic feed(input int n, input logic [31:0] w_word, input bit gaps);
    int sent = 0;
    int guard = 0;
    logic rdy;
    while (sent < n && guard < 200) begin
      @(negedge clk);
      guard++;
      if (gaps && (guard % 2 == 0)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1; in_a = a_vec[sent]; in_w = w_word;
      end
      rdy = in_ready;
      @(posedge clk);
      if (in_valid && rdy) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (guard >= 200) chk("feed_timeout", guard, 0);
  endtask

  // Drains four lanes and checks them against exp_v. When flush_chk is set,
  // the caller is on the falling edge just after the final beat was accepted.
  task automatic drain(input bit stalls, input bit flush_chk);
    int lane = 0;
    int guard = 0;
    if (flush_chk) begin
      chk("flush_out_valid", out_valid, 0);
      chk("flush_busy", busy, 1);
    end
    while (lane < 4 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (guard == 1) chk("first_out_valid", out_valid, 1);
      chk("drain_in_ready", in_ready, 0);
      if (out_valid) begin
        chk($sformatf("data_l%0d", lane), out_data, exp_v[lane]);
        chk($sformatf("lane_l%0d", lane), out_lane, lane);
        chk($sformatf("last_l%0d", lane), out_last, (lane == 3) ? 1 : 0);
        chk("drain_done_low", done, 0);
        out_ready = (stalls && (guard % 3 == 1)) ? 1'b0 : 1'b1;
        if (out_ready) lane++;
      end else begin
        out_ready = 1'b0;
      end
    end
    if (guard >= 100) chk("drain_timeout", guard, 0);
    @(negedge clk);
    out_ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("idle_busy", busy, 0);
    chk("idle_out_valid", out_valid, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    rst = 1'b0; start = 0; abort = 0; len = 0; sat_en = 0;
    in_valid = 0; in_a = 0; in_w = 0; out_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_done", done, 0);
    rst = 1'b1;

    // Test 1: a=1,2,3 with lane weights 1..4 gives 6,12,18,24.
    a_vec[0] = 1; a_vec[1] = 2; a_vec[2] = 3;
    exp_v[0] = 6; exp_v[1] = 12; exp_v[2] = 18; exp_v[3] = 24;
    start_job(8'd3, 1'b0);
    feed(3, 32'h04030201, 1'b0);
    drain(1'b0, 1'b1);
    chk("t1_ovf", ovf, 0);

    // Test 2: same job with input bubbles and output stalls.
    start_job(8'd3, 1'b0);
    feed(3, 32'h04030201, 1'b1);
    drain(1'b1, 1'b1);
    chk("t2_ovf", ovf, 0);

    // Test 3: 4 x 127*127 = 64516 per lane. It saturates to 32767 or wraps to -1020.
    for (int i = 0; i < 4; i++) a_vec[i] = 127;
    for (int i = 0; i < 4; i++) exp_v[i] = 32767;
    start_job(8'd4, 1'b1);
    feed(4, 32'h7F7F7F7F, 1'b0);
    drain(1'b0, 1'b1);
    chk("t3_sat_ovf", ovf, 4'hF);
    for (int i = 0; i < 4; i++) exp_v[i] = -1020;
    start_job(8'd4, 1'b0);
    feed(4, 32'h7F7F7F7F, 1'b0);
    drain(1'b0, 1'b1);
    chk("t3_wrap_ovf", ovf, 4'hF);

    // Test 4: len=0 drains four zero results and consumes no beats.
    for (int i = 0; i < 4; i++) exp_v[i] = 0;
    start_job(8'd0, 1'b0);
    drain(1'b0, 1'b0);
    chk("t4_ovf", ovf, 0);

    // Test 5: start inside ACCUM is ignored. Abort after 2 of 5 beats.
    a_vec[0] = 5; a_vec[1] = 7;
    start_job(8'd5, 1'b0);
    feed(1, 32'h01010101, 1'b0);
    start_job(8'd1, 1'b0);
    @(negedge clk);
    chk("t5_busy_after_start", busy, 1);
    chk("t5_in_ready_after_start", in_ready, 1);
    a_vec[0] = 7;
    feed(1, 32'h01010101, 1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_in_ready", in_ready, 0);
    chk("t5_abort_done", done, 0);
    @(negedge clk);
    chk("t5_abort_done_later", done, 0);
    a_vec[0] = -2;
    for (int i = 0; i < 4; i++) exp_v[i] = -10;
    start_job(8'd1, 1'b0);
    feed(1, 32'h05050505, 1'b0);
    drain(1'b0, 1'b1);

    // Test 6: asynchronous reset while lane 1 is stalled.
    a_vec[0] = 3;
    start_job(8'd1, 1'b1);
    feed(1, 32'h01010101, 1'b0);
    @(negedge clk);
    chk("t6_l0_valid", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("t6_l1_lane", out_lane, 1);
    @(negedge clk);
    chk("t6_l1_stall_data", out_data, 3);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_out_lane", out_lane, 0);
    chk("t6_rst_out_data", out_data, 0);
    chk("t6_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    a_vec[0] = 1; a_vec[1] = 2; a_vec[2] = 3;
    exp_v[0] = 6; exp_v[1] = 12; exp_v[2] = 18; exp_v[3] = 24;
    start_job(8'd3, 1'b0);
    feed(3, 32'h04030201, 1'b0);
    drain(1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
